// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// per-stage instruction metadata carried by the shadow pipeline.
package Pipe_Buf_Reg_PKG;

    // Register indices are zero-extended into this width; RF_ADDRESS must not exceed it.
    localparam int HZ_IDX_W = 8;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic [HZ_IDX_W-1:0] rs1;
        logic [HZ_IDX_W-1:0] rs2;
        logic [HZ_IDX_W-1:0] rd;
    } hz_meta_t;

    localparam hz_meta_t HZ_NOP = '0;

    function automatic logic is_mem_op(input hz_meta_t m);
        return m.valid & (m.memread | m.memwrite);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority forwarding match: picks the youngest post-EX stage writing the
// requested source register; x0 never matches.
module fwd_select #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 8,
    parameter int SEL_W = 2
) (
    input  logic [IDX_W-1:0]             src,
    input  logic [DEPTH-1:0]             cand_valid,
    input  logic [DEPTH-1:0][IDX_W-1:0]  cand_rd,
    output logic [SEL_W-1:0]             sel
);

    // Walk oldest to youngest so the smallest matching stage number wins.
    always_comb begin
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (cand_valid[k] && (cand_rd[k] != '0) && (cand_rd[k] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: load-use stalls, branch
// redirects, memory-wait stalls, operand forwarding and event counters.
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int RF_ADDRESS = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  br_taken,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  mem_wb_bubble,
    output logic [SEL_W-1:0]      fa_sel,
    output logic [SEL_W-1:0]      fb_sel,
    output logic                  redirect,
    output logic [CNT_W-1:0]      cnt_load_use,
    output logic [CNT_W-1:0]      cnt_mem_wait,
    output logic [CNT_W-1:0]      cnt_flush
);

    hz_state_t state_q, state_d;
    hz_meta_t  ex_q;
    hz_meta_t  stg_q [1:FWD_DEPTH];
    hz_meta_t  id_entry;

    logic mem_op, req_int, mem_stall, redirect_int, load_use;
    logic [SEL_W-1:0] fa_raw, fb_raw;
    logic [FWD_DEPTH-1:0]               cand_valid;
    logic [FWD_DEPTH-1:0][HZ_IDX_W-1:0] cand_rd;

    always_comb begin
        id_entry          = HZ_NOP;
        id_entry.valid    = id_valid;
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
        id_entry.memwrite = id_memwrite;
        id_entry.rs1      = HZ_IDX_W'(id_rs1);
        id_entry.rs2      = HZ_IDX_W'(id_rs2);
        id_entry.rd       = HZ_IDX_W'(id_rd);
    end

    // Hazard detection; the MEM_WAIT state keeps the request up until the ack.
    always_comb begin
        mem_op       = is_mem_op(stg_q[1]);
        req_int      = (state_q == MEM_WAIT) | mem_op;
        mem_stall    = req_int & ~dmem_ack;
        redirect_int = br_taken & ~mem_stall;
        load_use     = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                       ((ex_q.rd == id_entry.rs1) | (ex_q.rd == id_entry.rs2)) &
                       ~mem_stall & ~redirect_int;
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_op && !dmem_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ack) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            cand_valid[k] = stg_q[k+1].valid & stg_q[k+1].regwrite;
            cand_rd[k]    = stg_q[k+1].rd;
        end
    end

    fwd_select #(.DEPTH(FWD_DEPTH), .IDX_W(HZ_IDX_W), .SEL_W(SEL_W)) u_fwd_a (
        .src(ex_q.rs1), .cand_valid(cand_valid), .cand_rd(cand_rd), .sel(fa_raw)
    );

    fwd_select #(.DEPTH(FWD_DEPTH), .IDX_W(HZ_IDX_W), .SEL_W(SEL_W)) u_fwd_b (
        .src(ex_q.rs2), .cand_valid(cand_valid), .cand_rd(cand_rd), .sel(fb_raw)
    );

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        redirect      = 1'b0;
        dmem_req      = req_int;
        fa_sel        = fa_raw;
        fb_sel        = fb_raw;
        if (reset) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            dmem_req      = 1'b0;
            fa_sel        = '0;
            fb_sel        = '0;
        end else if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (redirect_int) begin
            redirect      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    // Shadow entries track the datapath registers exactly, including bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            ex_q         <= HZ_NOP;
            for (int k = 1; k <= FWD_DEPTH; k++) stg_q[k] <= HZ_NOP;
            cnt_load_use <= '0;
            cnt_mem_wait <= '0;
            cnt_flush    <= '0;
        end else begin
            state_q <= state_d;
            if (id_ex_en) ex_q <= id_ex_bubble ? HZ_NOP : id_entry;
            if (ex_mem_en) stg_q[1] <= ex_q;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                stg_q[k] <= ((k == 2) && mem_wb_bubble) ? HZ_NOP : stg_q[k-1];
            end
            if (load_use && (cnt_load_use != '1)) cnt_load_use <= cnt_load_use + CNT_W'(1);
            if (mem_stall && (cnt_mem_wait != '1)) cnt_mem_wait <= cnt_mem_wait + CNT_W'(1);
            if (redirect_int && (cnt_flush != '1)) cnt_flush <= cnt_flush + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RF_ADDRESS, default 5, register-index width.
REQ-002 Parameter FWD_DEPTH, default 2, number of post-EX stages eligible to forward (1 = EX/MEM, 2 = MEM/WB, 3+ = extra write-back stages).
REQ-003 Parameter CNT_W, default 16, performance-counter width.
REQ-004 Localparam SEL_W = $clog2(FWD_DEPTH+1).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 id_valid, id_regwrite, id_memread, id_memwrite  in  1 each  decoded attributes of the instruction in ID.
REQ-008 id_rs1, id_rs2, id_rd  in  RF_ADDRESS each  ID register indices.
REQ-009 br_taken  in  1  EX-stage redirect (taken branch, jal, jalr).
REQ-010 dmem_ack  in  1  data memory completes the current MEM-stage access this cycle.
REQ-011 dmem_req  out  1  MEM-stage access outstanding.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage-register load enables.
REQ-013 if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  load NOP into that register.
REQ-014 fa_sel, fb_sel  out  SEL_W each  forward source for EX operand A/B; 0 = register file, k = stage k.
REQ-015 redirect  out  1  select branch target for next PC.
REQ-016 cnt_load_use, cnt_mem_wait, cnt_flush  out  CNT_W each  saturating event counters.

Function
REQ-017 Internal shadow pipeline: entries EX, then stages 1..FWD_DEPTH; each holds valid, regwrite, memread, memwrite, rs1, rs2, rd; advances exactly when the corresponding datapath enable is high.
REQ-018 FSM states RUN, MEM_WAIT; encoding in shared package.
REQ-019 mem_op = stage-1 valid & (memread | memwrite); dmem_req = mem_op in RUN, or 1 in MEM_WAIT.
REQ-020 RUN -> MEM_WAIT when mem_op & ~dmem_ack; MEM_WAIT -> RUN on dmem_ack; same-cycle ack in RUN causes zero stall.
REQ-021 mem_stall = dmem_req & ~dmem_ack; while high: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_bubble = 1; redirect = 0; load-use ignored.
REQ-022 redirect = br_taken & ~mem_stall; when high: if_id_flush = 1, id_ex_bubble = 1, all enables = 1.
REQ-023 load_use = EX valid & EX memread & EX rd != 0 & id_valid & (EX rd == id_rs1 | EX rd == id_rs2); effective only when ~mem_stall & ~redirect.
REQ-024 Load-use: pc_en = 0, if_id_en = 0, id_ex_bubble = 1, ex_mem_en = 1; stall lasts exactly one cycle per hazard.
REQ-025 Priority: mem_stall > redirect > load_use > normal (all enables 1, no flush/bubble).
REQ-026 fa_sel = smallest k in 1..FWD_DEPTH with stage-k valid & regwrite & rd != 0 & rd == EX rs1; else 0; fb_sel identical on rs2; purely combinational from shadow state.
REQ-027 x0 never forwards and never triggers load-use.
REQ-028 Counters increment by 1 per cycle of load_use (effective), mem_stall, redirect respectively; saturate at all-ones; no wrap.
REQ-029 Bubbles clear valid in the shadow entry; flushed instructions never forward or stall.

Reset
REQ-030 On reset: FSM = RUN, all shadow valid = 0, counters = 0.
REQ-031 Outputs while reset high: enables = 1, if_id_flush = id_ex_bubble = mem_wb_bubble = 1, dmem_req = 0, redirect = 0, fa_sel = fb_sel = 0.
REQ-032 Reset during MEM_WAIT abandons the access; dmem_req deasserts the following cycle-edge-registered state, with no residual stall.

Structure
REQ-033 State enum and shadow-entry struct (hz_meta_t) live in Pipe_Buf_Reg_PKG.
REQ-034 One sub-module fwd_select (priority match of one source index against FWD_DEPTH entries), instantiated for rs1 and rs2.

Verification
REQ-035 lw x5 then add x6,x5,x1 -> one cycle pc_en = 0, id_ex_bubble = 1; then fa_sel = 2; cnt_load_use = 1.
REQ-036 add x5 then sub x7,x5,x5 back-to-back -> fa_sel = fb_sel = 1, no stall.
REQ-037 sw in stage 1, dmem_ack low 3 cycles -> mem_stall 3 cycles, mem_wb_bubble 3 cycles, cnt_mem_wait = 3, state back to RUN on ack.
REQ-038 br_taken coincident with mem_stall -> redirect = 0 until ack, then redirect = 1 one cycle; cnt_flush = 1.
REQ-039 addi x0 then consumer of x0 -> fa_sel = 0, no stall; CNT_W = 2 with 5 load-use events -> counter = 3.
REQ-040 reset asserted in MEM_WAIT -> next cycle state RUN, all valid = 0, dmem_req = 0.
